// File: rtl/rc_div_sequencer_if.sv
// Bus between the divider sequencer and its surroundings.
// Carries the request (start, dividend, divisor), the result
// (busy, done, quotient, remainder, div_by_zero) and the time-shared
// add/sub unit connection (add_a, add_b, add_sna driven by the divider;
// add_y, add_co returned by the adder).
//   slave  : divider side
//   master : requester + adder side
interface rc_div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_sna;
  logic [WIDTH-1:0] add_y;
  logic             add_co;

  modport slave (
    input  start, dividend, divisor, add_y, add_co,
    output busy, done, quotient, remainder, div_by_zero, add_a, add_b, add_sna
  );

  modport master (
    output start, dividend, divisor, add_y, add_co,
    input  busy, done, quotient, remainder, div_by_zero, add_a, add_b, add_sna
  );
endinterface

// File: rtl/rc_div_sequencer.sv
// Multi-cycle unsigned restoring divider controller.
// Shares one external WIDTH-bit add/sub unit, one trial subtract per cycle.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high; aborts any op in flight
//   bus  : rc_div_sequencer_if.slave (request, result, adder drive/return)
// Flow: IDLE --start--> RUN (WIDTH iterations) --> FIN (done pulse) --> IDLE.
// A zero divisor skips RUN and goes straight to FIN with div_by_zero set.
module rc_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  rc_div_sequencer_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] r, q, d;
  logic [CW-1:0]    cnt;
  logic             dbz;

  logic             run;
  logic [WIDTH-1:0] shifted;
  logic             ok;

  assign run     = (state == S_RUN);
  // Partial remainder shifted left with the next dividend bit pulled in from q.
  assign shifted = {r[WIDTH-2:0], q[WIDTH-1]};
  // r[W-1] is the bit shifted out of the window: the true value is >= 2^W > d,
  // so the subtract must succeed and its W-bit difference is exact.
  assign ok      = r[WIDTH-1] | bus.add_co;

  // Adder is only driven during RUN so it stays quiet otherwise.
  assign bus.add_a   = run ? shifted : '0;
  assign bus.add_b   = run ? d : '0;
  assign bus.add_sna = run;

  assign bus.busy        = run;
  assign bus.done        = (state == S_FIN);
  assign bus.quotient    = q;
  assign bus.remainder   = r;
  assign bus.div_by_zero = dbz;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      r     <= '0;
      q     <= '0;
      d     <= '0;
      cnt   <= '0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            d   <= bus.divisor;
            cnt <= '0;
            if (bus.divisor == '0) begin
              q     <= '1;
              r     <= bus.dividend;
              dbz   <= 1'b1;
              state <= S_FIN;
            end else begin
              q     <= bus.dividend;
              r     <= '0;
              dbz   <= 1'b0;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r   <= ok ? bus.add_y : shifted;
          q   <= {q[WIDTH-2:0], ok};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= S_FIN;
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rc_div_sequencer.sv
module tb_rc_div_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rc_div_sequencer_if #(.WIDTH(W)) bus ();

  rc_div_sequencer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // External add/sub unit: Y = A + (B ^ {W{SnA}}) + SnA, CO = carry out.
  logic [W:0] add_full;
  assign add_full   = {1'b0, bus.add_a} + {1'b0, bus.add_b ^ {W{bus.add_sna}}} + {{W{1'b0}}, bus.add_sna};
  assign bus.add_y  = add_full[W-1:0];
  assign bus.add_co = add_full[W];

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   accepted = 0;
  int   done_cnt = 0;
  logic [W-1:0] last_q, last_r;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic division with the divide-by-zero convention.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: checks every done pulse against the scoreboard and idle adder quiet.
  always @(negedge clk) begin
    if (!rst) begin
      if (!bus.busy) begin
        chk("adder_quiet", {bus.add_a, bus.add_b[W-2:0], bus.add_sna}, 64'd0);
      end
      if (bus.done) begin
        done_cnt++;
        chk("busy_in_fin", {63'd0, bus.busy}, 64'd0);
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got done expected none (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient",    {32'd0, bus.quotient},  {32'd0, e.q});
          chk("remainder",   {32'd0, bus.remainder}, {32'd0, e.r});
          chk("div_by_zero", {63'd0, bus.div_by_zero}, {63'd0, e.dbz});
          chk("done_cycle",  64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || bus.done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: got busy expected idle within 200 cycles");
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    wait_idle();
    e = model(a, b);
    // accept edge is the next posedge (cyc+1); done is seen after it or after +W more
    e.cyc = cyc + 1 + ((b == '0) ? 0 : W);
    sb.push_back(e);
    last_q = e.q; last_r = e.r;
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    accepted++;
    @(negedge clk);
    bus.start = 1'b0;
    chk("accepted", {63'd0, (bus.busy | bus.done)}, 64'd1);
  endtask

  task automatic rand_op();
    logic [W-1:0] a, b;
    a = $urandom; b = $urandom;
    case ($urandom_range(0, 7))
      0: b = '0;
      1: a = '0;
      2: begin a = '1; if ($urandom_range(0, 1) == 1) b = '1; end
      3: b = W'($urandom_range(1, 15));
      4: a = W'($urandom_range(0, 255));
      5: b = b >> $urandom_range(0, 31);
      default: ;
    endcase
    do_op(a, b);
  endtask

  initial begin
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    last_q = '0; last_r = '0;
    repeat (3) @(negedge clk);
    // reset state
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_q",    {32'd0, bus.quotient}, 64'd0);
    chk("rst_r",    {32'd0, bus.remainder}, 64'd0);
    chk("rst_dbz",  {63'd0, bus.div_by_zero}, 64'd0);
    chk("rst_add",  {bus.add_a, bus.add_b[W-2:0], bus.add_sna}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed cases
    do_op(32'd100, 32'd7);
    do_op(32'hFFFF_FFFF, 32'd1);
    do_op(32'hFFFF_FFFF, 32'h8000_0000);
    do_op(32'd5, 32'd0);
    do_op(32'd0, 32'd9);

    // start pulse during RUN must be ignored
    do_op(32'd3, 32'd9);
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    @(negedge clk);
    chk("held_q", {32'd0, bus.quotient},  {32'd0, last_q});
    chk("held_r", {32'd0, bus.remainder}, {32'd0, last_r});

    // reset mid-op: no done for the aborted op
    do_op(32'd1000, 32'd3);
    repeat (16) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    accepted--;
    @(negedge clk);
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_done", {63'd0, bus.done}, 64'd0);
    chk("abort_q",    {32'd0, bus.quotient}, 64'd0);
    chk("abort_r",    {32'd0, bus.remainder}, 64'd0);
    chk("abort_add",  {bus.add_a, bus.add_b[W-2:0], bus.add_sna}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    do_op(32'd1000, 32'd3);

    // randomized
    for (int i = 0; i < 1200; i++) rand_op();

    wait_idle();
    repeat (3) @(negedge clk);
    chk("sb_empty",   64'(sb.size()), 64'd0);
    chk("done_count", 64'(done_cnt), 64'(accepted));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
